// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the shared-memory side and the
// contention counter. The arbiter binds the slave modport.
interface mem_arbiter_if #(
    parameter int CNT_W = 16
);
    // Handshake: a requester raises mX_req with we/addr/wdata and holds all of
    // them stable until mX_gnt is seen high in the same cycle; that cycle is the
    // transfer. Reads return on mX_rvalid one cycle later with data on rdata.
    logic             m0_req;
    logic             m1_req;
    logic             m0_we;
    logic             m1_we;
    logic [31:0]      m0_addr;
    logic [31:0]      m1_addr;
    logic [31:0]      m0_wdata;
    logic [31:0]      m1_wdata;
    logic             m1_lock;
    logic             m0_gnt;
    logic             m1_gnt;
    logic             m0_rvalid;
    logic             m1_rvalid;
    logic [31:0]      rdata;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output m0_req, m1_req, m0_we, m1_we,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m1_lock, mem_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write, conflict_cnt
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m1_lock, mem_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
        output mem_addr, mem_wdata, mem_read, mem_write, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: round-robin owner
// FSM, bounded burst hold for port 1, registered read return, contention counter.
module mem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic [3:0]       r_burst_cnt;
    logic [31:0]      r_rdata;
    logic             r_m0_rvalid;
    logic             r_m1_rvalid;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic             w_m0_gnt;
    logic             w_m1_gnt;
    logic             w_burst_hold;
    logic             w_contend;
    logic [31:0]      w_mem_addr;
    logic [31:0]      w_mem_wdata;
    logic             w_mem_read;
    logic             w_mem_write;

    assign w_m0_gnt     = (r_state == ST_OWN0) & bus.m0_req;
    assign w_m1_gnt     = (r_state == ST_OWN1) & bus.m1_req;
    assign w_burst_hold = bus.m1_req & bus.m1_lock & (r_burst_cnt < BURST_LAST);
    assign w_contend    = (bus.m0_req & ~w_m0_gnt) | (bus.m1_req & ~w_m1_gnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The requester that lost the last grant wins a tie out of IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    w_next_state = r_last_grant ? ST_OWN0 : ST_OWN1;
                end else if (bus.m0_req) begin
                    w_next_state = ST_OWN0;
                end else if (bus.m1_req) begin
                    w_next_state = ST_OWN1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (bus.m1_req) begin
                    w_next_state = ST_OWN1;
                end else if (bus.m0_req) begin
                    w_next_state = ST_OWN0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (w_burst_hold) begin
                    w_next_state = ST_OWN1;
                end else if (bus.m0_req) begin
                    w_next_state = ST_OWN0;
                end else if (bus.m1_req) begin
                    w_next_state = ST_OWN1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mem_addr  = 32'h0;
        w_mem_wdata = 32'h0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        if (w_m0_gnt) begin
            w_mem_addr  = bus.m0_addr;
            w_mem_wdata = bus.m0_wdata;
            w_mem_write = bus.m0_we;
            w_mem_read  = ~bus.m0_we;
        end else if (w_m1_gnt) begin
            w_mem_addr  = bus.m1_addr;
            w_mem_wdata = bus.m1_wdata;
            w_mem_write = bus.m1_we;
            w_mem_read  = ~bus.m1_we;
        end
    end

    // Counter saturates so a long unlocked tenure cannot wrap into extra lock grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= 4'd0;
        end else if ((r_state == ST_OWN1) && (w_next_state != ST_OWN1)) begin
            r_burst_cnt <= 4'd0;
        end else if (w_m1_gnt && (r_burst_cnt != 4'hF)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_m0_gnt) begin
            r_last_grant <= 1'b0;
        end else if (w_m1_gnt) begin
            r_last_grant <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata     <= 32'h0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_m0_gnt & ~bus.m0_we;
            r_m1_rvalid <= w_m1_gnt & ~bus.m1_we;
            if (w_mem_read) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_contend && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign bus.m0_gnt       = w_m0_gnt;
    assign bus.m1_gnt       = w_m1_gnt;
    assign bus.m0_rvalid    = r_m0_rvalid;
    assign bus.m1_rvalid    = r_m1_rvalid;
    assign bus.rdata        = r_rdata;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.mem_read     = w_mem_read;
    assign bus.mem_write    = w_mem_write;
    assign bus.conflict_cnt = r_conflict_cnt;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level reference of who owns the memory and what it returns.
module tb_mem_arbiter;

  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_s;

  logic        s_m0_req = 1'b0, s_m1_req = 1'b0;
  logic        s_m0_we = 1'b0, s_m1_we = 1'b0;
  logic [31:0] s_m0_addr = '0, s_m1_addr = '0;
  logic [31:0] s_m0_wdata = '0, s_m1_wdata = '0;
  logic        s_m1_lock = 1'b0;

  logic [31:0] tb_mem [16];

  mem_arbiter_if #(.CNT_W(16)) bus ();
  mem_arbiter_if #(.CNT_W(4))  bus_s ();

  mem_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );
  mem_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s), .o_dbg_state(dbg_state_s)
  );

  assign bus.m0_req   = s_m0_req;    assign bus_s.m0_req   = s_m0_req;
  assign bus.m1_req   = s_m1_req;    assign bus_s.m1_req   = s_m1_req;
  assign bus.m0_we    = s_m0_we;     assign bus_s.m0_we    = s_m0_we;
  assign bus.m1_we    = s_m1_we;     assign bus_s.m1_we    = s_m1_we;
  assign bus.m0_addr  = s_m0_addr;   assign bus_s.m0_addr  = s_m0_addr;
  assign bus.m1_addr  = s_m1_addr;   assign bus_s.m1_addr  = s_m1_addr;
  assign bus.m0_wdata = s_m0_wdata;  assign bus_s.m0_wdata = s_m0_wdata;
  assign bus.m1_wdata = s_m1_wdata;  assign bus_s.m1_wdata = s_m1_wdata;
  assign bus.m1_lock  = s_m1_lock;   assign bus_s.m1_lock  = s_m1_lock;
  assign bus.mem_rdata   = tb_mem[bus.mem_addr[5:2]];
  assign bus_s.mem_rdata = tb_mem[bus_s.mem_addr[5:2]];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'hDEADBEEF : (32'hA500_0000 + 32'(i));
  endfunction

  // Memory behind the arbiter: write lands at the edge closing the grant cycle.
  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write) tb_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          holder;      // -1 nobody, 0 or 1 = port holding the memory
  int          last_win;    // port that got the most recent grant
  int          run;         // grants port 1 has already taken in its current holding
  int          cnt;         // unbounded count of cycles with a waiting requester
  bit          exp_rv0, exp_rv1;
  logic [31:0] exp_rdata;
  logic [31:0] ref_mem [16];
  logic [32:0] exp_q[$];    // {port, data} of reads in flight
  int          m_gid;       // port the model granted in the last step

  logic        o_g0, o_g1, o_rv0, o_rv1, o_mr, o_mw;
  logic [31:0] o_rdata, o_maddr, o_mwdata, o_cnt, o_cnt_s;
  int          o_gid;

  task automatic model_reset();
    holder = -1; last_win = 1; run = 0; cnt = 0;
    exp_rv0 = 0; exp_rv1 = 0; exp_rdata = '0;
    exp_q.delete();
  endtask

  function automatic int next_holder(input int h, input bit r0, input bit r1, input bit lk,
                                     input int grants_so_far, input int last);
    if (h == -1) begin
      if (r0 && r1) return 1 - last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    if (h == 0) begin
      if (r1) return 1;
      if (r0) return 0;
      return -1;
    end
    if (r1 && lk && (grants_so_far + 1 < MAX_BURST)) return 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock: compare the DUT against the model mid-cycle, then advance the model.
  task automatic step();
    bit g0, g1, wr, rd;
    logic [31:0] ea, ew, e;
    int nh;
    @(negedge clk);
    g0 = (holder == 0) && s_m0_req;
    g1 = (holder == 1) && s_m1_req;
    ea = g0 ? s_m0_addr : (g1 ? s_m1_addr : 32'h0);
    ew = g0 ? s_m0_wdata : (g1 ? s_m1_wdata : 32'h0);
    wr = g0 ? s_m0_we : (g1 ? s_m1_we : 1'b0);
    rd = (g0 || g1) && !wr;

    o_g0 = bus.m0_gnt; o_g1 = bus.m1_gnt; o_rv0 = bus.m0_rvalid; o_rv1 = bus.m1_rvalid;
    o_mr = bus.mem_read; o_mw = bus.mem_write; o_maddr = bus.mem_addr; o_mwdata = bus.mem_wdata;
    o_rdata = bus.rdata; o_cnt = 32'(bus.conflict_cnt); o_cnt_s = 32'(bus_s.conflict_cnt);
    o_gid = o_g0 ? 0 : (o_g1 ? 1 : -1);

    check_val("m0_gnt", o_g0, g0);
    check_val("m1_gnt", o_g1, g1);
    check_val("mem_addr", o_maddr, ea);
    check_val("mem_wdata", o_mwdata, ew);
    check_val("mem_read", o_mr, rd);
    check_val("mem_write", o_mw, wr);
    check_val("m0_rvalid", o_rv0, exp_rv0);
    check_val("m1_rvalid", o_rv1, exp_rv1);
    check_val("rdata", o_rdata, exp_rdata);
    check_val("conflict_cnt", o_cnt, 32'(sat(cnt, 65535)));
    check_val("conflict_cnt_w4", o_cnt_s, 32'(sat(cnt, 15)));
    if (o_rv0 || o_rv1) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_rvalid", {30'd0, o_rv1, o_rv0}, 32'd0);
      end else begin
        e = exp_q[0][31:0];
        check_val("sb_port", o_rv1, exp_q[0][32]);
        check_val("sb_rdata", o_rdata, e);
        void'(exp_q.pop_front());
      end
    end

    if (reset) begin
      model_reset();
      g0 = 0; g1 = 0;
    end else begin
      if ((s_m0_req && !g0) || (s_m1_req && !g1)) cnt++;
      exp_rv0 = g0 && !s_m0_we;
      exp_rv1 = g1 && !s_m1_we;
      if (rd) begin
        exp_rdata = ref_mem[ea[5:2]];
        exp_q.push_back({g1, ref_mem[ea[5:2]]});
      end
      if (wr) ref_mem[ea[5:2]] = ew;
      nh = next_holder(holder, s_m0_req, s_m1_req, s_m1_lock, run, last_win);
      if (g0) last_win = 0;
      if (g1) last_win = 1;
      run = (holder == 1 && nh == 1) ? run + 1 : 0;
      holder = nh;
    end
    m_gid = g0 ? 0 : (g1 ? 1 : -1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_m0(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    s_m0_req = req; s_m0_we = we; s_m0_addr = addr; s_m0_wdata = wdata;
  endtask

  task automatic drive_m1(input bit req, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit lock);
    s_m1_req = req; s_m1_we = we; s_m1_addr = addr; s_m1_wdata = wdata; s_m1_lock = lock;
  endtask

  task automatic idle_ports();
    drive_m0(0, 0, 32'h0, 32'h0);
    drive_m1(0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_ports();
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 1) == 1) ? 32'h4000_0000 : 32'h0);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int tie_exp [6];
    int burst_exp [8];
    tie_exp   = '{-1, 0, 1, 0, 1, 0};
    burst_exp = '{-1, 0, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    m_gid = -1;

    // Reset state.
    apply_reset();
    check_val("rst_gnt", {o_g1, o_g0}, 2'b00);
    check_val("rst_rvalid", {o_rv1, o_rv0}, 2'b00);
    check_val("rst_mem_ctl", {o_mw, o_mr}, 2'b00);
    check_val("rst_rdata", o_rdata, 32'h0);
    check_val("rst_cnt", o_cnt, 32'h0);

    // Single read from port 0.
    drive_m0(1, 0, 32'h100, 32'h0);
    step();
    check_val("rd_t0_gnt", o_g0, 1'b0);
    step();
    check_val("rd_t1_gnt", o_g0, 1'b1);
    check_val("rd_t1_addr", o_maddr, 32'h100);
    drive_m0(0, 0, 32'h0, 32'h0);
    step();
    check_val("rd_t2_rvalid", o_rv0, 1'b1);
    check_val("rd_t2_rdata", o_rdata, 32'hDEADBEEF);
    check_val("rd_t2_cnt", o_cnt, 32'd1);
    step();
    check_val("rd_t3_rvalid", o_rv0, 1'b0);

    // Tie from reset: port 0 first, then alternation.
    apply_reset();
    drive_m0(1, 0, 32'h8, 32'h0);
    drive_m1(1, 0, 32'hC, 32'h0, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_val($sformatf("tie_gnt%0d", k), o_gid, tie_exp[k]);
      check_val($sformatf("tie_cnt%0d", k), o_cnt, 32'(k));
    end
    idle_ports();
    repeat (2) step();

    // Burst lock: four port-1 grants before port 0 gets back in.
    apply_reset();
    drive_m0(1, 0, 32'h10, 32'h0);
    drive_m1(1, 0, 32'h14, 32'h0, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      check_val($sformatf("burst_gnt%0d", k), o_gid, burst_exp[k]);
    end
    idle_ports();
    repeat (2) step();

    // Write passthrough from port 1, then read it back through port 0.
    apply_reset();
    drive_m1(1, 1, 32'h4000_000C, 32'h55, 0);
    step();
    step();
    check_val("wr_gnt", o_g1, 1'b1);
    check_val("wr_mem_write", o_mw, 1'b1);
    check_val("wr_mem_read", o_mr, 1'b0);
    check_val("wr_addr", o_maddr, 32'h4000_000C);
    check_val("wr_wdata", o_mwdata, 32'h55);
    drive_m1(0, 0, 32'h0, 32'h0, 0);
    step();
    check_val("wr_no_rvalid", {o_rv1, o_rv0}, 2'b00);
    check_val("wr_one_cycle", o_mw, 1'b0);
    drive_m0(1, 0, 32'h4000_000C, 32'h0);
    step();
    step();
    drive_m0(0, 0, 32'h0, 32'h0);
    step();
    check_val("wr_readback", o_rdata, 32'h55);

    // Reset arriving while a read return is due.
    apply_reset();
    drive_m0(1, 0, 32'h100, 32'h0);
    step();
    step();
    check_val("rstrd_gnt", o_g0, 1'b1);
    drive_m0(0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    model_reset();
    step();
    check_val("rstrd_rvalid", o_rv0, 1'b0);
    check_val("rstrd_rdata", o_rdata, 32'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val($sformatf("rstrd_after%0d", k), o_rv0, 1'b0);
    end

    // Saturation of the narrow counter under continuous contention.
    apply_reset();
    drive_m0(1, 0, 32'h20, 32'h0);
    drive_m1(1, 0, 32'h24, 32'h0, 0);
    repeat (21) step();
    check_val("sat_w16", o_cnt, 32'd20);
    check_val("sat_w4", o_cnt_s, 32'd15);
    repeat (3) step();
    check_val("sat_hold", o_cnt_s, 32'd15);
    idle_ports();
    repeat (2) step();

    // Random traffic; a port only changes its request once granted or idle.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!s_m0_req || m_gid == 0)
        drive_m0($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!s_m1_req || m_gid == 1) begin
        s_m1_req = $urandom_range(0, 99) < 60;
        s_m1_we = 1'($urandom_range(0, 1));
        s_m1_addr = rand_addr();
        s_m1_wdata = $urandom;
      end
      s_m1_lock = $urandom_range(0, 99) < 70;
      step();
    end
    idle_ports();
    repeat (3) step();
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
